// File: rtl/lcd_reader.sv
// HD44780-compatible 4-bit read engine: drives RW/RS/E and assembles one byte
// from two enable pulses (upper nibble first). Optional busy-poll mode keeps
// re-reading status until BF clears or the poll budget is exhausted.
module lcd_reader #(
  parameter int SETUP_CYCLES  = 2,
  parameter int E_HIGH_CYCLES = 12,
  parameter int E_GAP_CYCLES  = 50,
  parameter int POLL_MAX      = 2048
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll_Busy,
  input  logic [3:0] iData_NIBBLE,
  output logic       oEnable,
  output logic       oRW,
  output logic       oRS,
  output logic       oBusy,
  output logic [7:0] oData_BYTE,
  output logic       oRead_Done,
  output logic       oTimeout
);

  // One counter width serves both the phase timer and the poll counter, sized
  // so that neither can wrap at its largest terminal value.
  localparam int MAX_AB  = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES : E_HIGH_CYCLES;
  localparam int MAX_CD  = (E_GAP_CYCLES > POLL_MAX) ? E_GAP_CYCLES : POLL_MAX;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] EHIGH_LAST = CW'(E_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] EGAP_LAST  = CW'(E_GAP_CYCLES - 1);
  localparam logic [CW-1:0] POLL_LIM   = CW'(POLL_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EH1,
    S_GAP,
    S_EH2,
    S_HOLD,
    S_PGAP,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] poll_cnt, poll_cnt_nxt;
  logic          rs_lat, rs_lat_nxt;
  logic          poll_lat, poll_lat_nxt;
  logic [3:0]    upper, upper_nxt;
  logic [3:0]    lower, lower_nxt;

  logic          enable_nxt;
  logic          rw_nxt;
  logic          rs_nxt;
  logic          busy_nxt;
  logic          done_nxt;
  logic [7:0]    data_nxt;
  logic          timeout_nxt;

  // Next-state, phase timing and nibble capture; outputs are derived from the
  // next state so that every LCD pin comes straight from a flop.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    poll_cnt_nxt = poll_cnt;
    rs_lat_nxt   = rs_lat;
    poll_lat_nxt = poll_lat;
    upper_nxt    = upper;
    lower_nxt    = lower;

    case (state)
      S_IDLE: begin
        if (iStart) begin
          rs_lat_nxt   = iRS;
          poll_lat_nxt = iPoll_Busy & ~iRS;
          poll_cnt_nxt = '0;
          cnt_nxt      = '0;
          state_nxt    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_EH1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_EH1: begin
        if (cnt == EHIGH_LAST) begin
          upper_nxt = iData_NIBBLE;
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == EGAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_EH2;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_EH2: begin
        if (cnt == EHIGH_LAST) begin
          lower_nxt    = iData_NIBBLE;
          poll_cnt_nxt = poll_cnt + 1'b1;
          cnt_nxt      = '0;
          state_nxt    = S_HOLD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HOLD: begin
        // BF is bit 7 of the status byte, i.e. bit 3 of the upper nibble.
        if (poll_lat && upper[3] && (poll_cnt < POLL_LIM)) begin
          cnt_nxt   = '0;
          state_nxt = S_PGAP;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_PGAP: begin
        // RW/RS never changed, so the next poll skips SETUP.
        if (cnt == EGAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_EH1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // RW stays high through DONE and drops only in IDLE, so the bus is never
    // contended while the LCD may still be driving it.
    enable_nxt  = (state_nxt == S_EH1) || (state_nxt == S_EH2);
    rw_nxt      = (state_nxt != S_IDLE);
    rs_nxt      = (state_nxt != S_IDLE) && rs_lat_nxt;
    busy_nxt    = (state_nxt != S_IDLE);
    done_nxt    = (state_nxt == S_DONE);
    data_nxt    = done_nxt ? {upper_nxt, lower_nxt} : oData_BYTE;
    timeout_nxt = done_nxt && poll_lat_nxt && upper_nxt[3];
  end

  // State, counters and latched request fields.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      poll_cnt <= '0;
      rs_lat   <= 1'b0;
      poll_lat <= 1'b0;
      upper    <= 4'h0;
      lower    <= 4'h0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      poll_cnt <= poll_cnt_nxt;
      rs_lat   <= rs_lat_nxt;
      poll_lat <= poll_lat_nxt;
      upper    <= upper_nxt;
      lower    <= lower_nxt;
    end
  end

  // Registered outputs; reset drops E on the very next cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      oEnable    <= 1'b0;
      oRW        <= 1'b0;
      oRS        <= 1'b0;
      oBusy      <= 1'b0;
      oData_BYTE <= 8'h00;
      oRead_Done <= 1'b0;
      oTimeout   <= 1'b0;
    end else begin
      oEnable    <= enable_nxt;
      oRW        <= rw_nxt;
      oRS        <= rs_nxt;
      oBusy      <= busy_nxt;
      oData_BYTE <= data_nxt;
      oRead_Done <= done_nxt;
      oTimeout   <= timeout_nxt;
    end
  end

endmodule
